noise_estimation: RTL and testbench

NOISE_ESTIMATION -- requirements
Module: noise_estimation

---
 rtl/noise_estimation_pkg.sv | 37 +++
 rtl/noise_div.sv | 67 ++++++
 rtl/noise_estimation.sv | 189 ++++++++++++++++++
 tb/tb_noise_estimation.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/noise_estimation_pkg.sv
// Shared state encoding and width derivations for the block-variance noise estimator.
package noise_estimation_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    BLK_VAR,
    ACCUM,
    DIVIDE,
    DONE
  } state_t;

  localparam int CNT_W     = 32;
  localparam int DIV_ITERS = 32;

  function automatic int log2n(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sum_w(input int dw, input int n);
    return dw + log2n(n);
  endfunction

  function automatic int sq_w(input int dw, input int n);
    return 2 * dw + log2n(n);
  endfunction

  function automatic int acc_w(input int dw);
    return 2 * dw + CNT_W;
  endfunction

endpackage

// File: rtl/noise_div.sv
// Restoring divider, fixed 32 iterations; the first iteration happens on the start edge.
// Assumes the quotient fits in 32 bits, so the dividend bits above bit 31 seed the remainder.
module noise_div
  import noise_estimation_pkg::*;
#(
  parameter int DIVIDEND_W = 48,
  parameter int QUOT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [31:0]           divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  logic [31:0] rem, lo, dvs;
  logic [31:0] rem_src, lo_src, dvs_src;
  logic [4:0]  iter;
  logic [32:0] step;

  function automatic logic [32:0] div_step(input logic [31:0] r, input logic b,
                                           input logic [31:0] d);
    logic [32:0] t;
    t = {r, b};
    if (t >= {1'b0, d}) div_step = {1'b1, 32'(t - {1'b0, d})};
    else                div_step = {1'b0, t[31:0]};
  endfunction

  // lo shifts dividend bits out of the top and quotient bits in at the bottom
  assign rem_src  = start ? 32'(dividend >> 32) : rem;
  assign lo_src   = start ? dividend[31:0] : lo;
  assign dvs_src  = start ? divisor : dvs;
  assign step     = div_step(rem_src, lo_src[31], dvs_src);
  assign quotient = lo[QUOT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rem  <= '0;
      lo   <= '0;
      dvs  <= '0;
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        rem <= step[31:0];
        lo  <= {lo_src[30:0], step[32]};
      end
      if (start) begin
        dvs  <= divisor;
        iter <= 5'd1;
        busy <= 1'b1;
      end else if (busy) begin
        iter <= iter + 5'd1;
        if (iter == 5'(DIV_ITERS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/noise_estimation.sv
// Frame noise estimator: per-block variance, then frame average (or minimum when
// NOISE_EST_MIN_EN is defined, which also removes the divider).
module noise_estimation
  import noise_estimation_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_of_frame,
  input  logic                    start_data,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [31:0]             blocks_per_frame,
  output logic [2*DATA_WIDTH-1:0] estimated_noise,
  output logic                    estimated_noise_ready
);

  localparam int LOG2N  = log2n(TOTAL_SAMPLES);
  localparam int SUM_W  = sum_w(DATA_WIDTH, TOTAL_SAMPLES);
  localparam int SQ_W   = sq_w(DATA_WIDTH, TOTAL_SAMPLES);
  localparam int ACC_W  = acc_w(DATA_WIDTH);
  localparam int OUT_W  = 2 * DATA_WIDTH;
  localparam int PROD_W = 2 * DATA_WIDTH + 2 * LOG2N;

  state_t           state, state_nxt;
  logic             blk_start, frame_clr, last_smp;
  logic [LOG2N-1:0] smp_cnt;
  logic [SUM_W-1:0] s_acc;
  logic [SQ_W-1:0]  q_acc, data_sq;
  logic [OUT_W-1:0] v_blk_p1;
  logic [CNT_W-1:0] blk_cnt, blk_cnt_inc, blk_target;
`ifdef NOISE_EST_MIN_EN
  logic [OUT_W-1:0] min_v, min_nxt;
`else
  logic [ACC_W-1:0] frame_acc, frame_sum;
  logic             div_start, div_busy, div_done;
  logic [OUT_W-1:0] div_quot;
`endif

  // Population variance scaled by N^2, then divided back down; always non-negative
  function automatic logic [OUT_W-1:0] blk_var(input logic [SUM_W-1:0] s,
                                               input logic [SQ_W-1:0] q);
    logic [PROD_W-1:0] nq, s2, diff;
    nq   = PROD_W'(q) << LOG2N;
    s2   = PROD_W'(s) * PROD_W'(s);
    diff = nq - s2;
    return OUT_W'(diff >> (2 * LOG2N));
  endfunction

  assign data_sq     = SQ_W'(data_in) * SQ_W'(data_in);
  assign last_smp    = (smp_cnt == LOG2N'(TOTAL_SAMPLES - 1));
  assign blk_cnt_inc = blk_cnt + CNT_W'(1);
`ifdef NOISE_EST_MIN_EN
  assign min_nxt = ((blk_cnt == '0) || (v_blk_p1 < min_v)) ? v_blk_p1 : min_v;
`else
  assign frame_sum = frame_acc + ACC_W'(v_blk_p1);
`endif
  assign estimated_noise_ready = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    blk_start = 1'b0;
    frame_clr = 1'b0;
`ifndef NOISE_EST_MIN_EN
    div_start = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_data) begin
          state_nxt = COLLECT;
          blk_start = 1'b1;
          frame_clr = start_of_frame;
        end
      end
      COLLECT: if (last_smp) state_nxt = BLK_VAR;
      BLK_VAR: state_nxt = ACCUM;
      ACCUM: begin
        if (blk_cnt_inc < blk_target) begin
          state_nxt = IDLE;
        end else begin
`ifdef NOISE_EST_MIN_EN
          state_nxt = DONE;
`else
          state_nxt = DIVIDE;
          div_start = 1'b1;
`endif
        end
      end
`ifdef NOISE_EST_MIN_EN
      DIVIDE: state_nxt = IDLE;
`else
      DIVIDE: begin
        // a new frame aborts the running division; its sample 0 is taken now
        if (start_data && start_of_frame) begin
          state_nxt = COLLECT;
          blk_start = 1'b1;
          frame_clr = 1'b1;
        end else if (!div_busy) begin
          state_nxt = DONE;
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      smp_cnt         <= '0;
      s_acc           <= '0;
      q_acc           <= '0;
      v_blk_p1        <= '0;
      blk_cnt         <= '0;
      blk_target      <= CNT_W'(1);
      estimated_noise <= '0;
`ifdef NOISE_EST_MIN_EN
      min_v           <= '0;
`else
      frame_acc       <= '0;
`endif
    end else begin
      // collect stage: running sum and sum of squares
      if (blk_start) begin
        smp_cnt <= LOG2N'(1);
        s_acc   <= SUM_W'(data_in);
        q_acc   <= data_sq;
      end else if (state == COLLECT) begin
        smp_cnt <= smp_cnt + LOG2N'(1);
        s_acc   <= s_acc + SUM_W'(data_in);
        q_acc   <= q_acc + data_sq;
      end
      // block variance stage
      if (state == BLK_VAR) v_blk_p1 <= blk_var(s_acc, q_acc);
      // frame accumulation stage
      if (frame_clr) begin
        blk_cnt    <= '0;
        blk_target <= (blocks_per_frame == '0) ? CNT_W'(1) : blocks_per_frame;
`ifdef NOISE_EST_MIN_EN
        min_v      <= '0;
`else
        frame_acc  <= '0;
`endif
      end else if (state == ACCUM) begin
        blk_cnt   <= blk_cnt_inc;
`ifdef NOISE_EST_MIN_EN
        min_v     <= min_nxt;
`else
        frame_acc <= frame_sum;
`endif
      end else if (state == DONE) begin
        blk_cnt   <= '0;
`ifdef NOISE_EST_MIN_EN
        min_v     <= '0;
`else
        frame_acc <= '0;
`endif
      end
`ifdef NOISE_EST_MIN_EN
      if ((state == ACCUM) && (state_nxt == DONE)) estimated_noise <= min_nxt;
`else
      if ((state == DIVIDE) && div_done && !frame_clr) estimated_noise <= div_quot;
`endif
    end
  end

`ifndef NOISE_EST_MIN_EN
  noise_div #(
    .DIVIDEND_W(ACC_W),
    .QUOT_W    (OUT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(frame_sum),
    .divisor (blk_target),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );
`endif

endmodule

// File: tb/tb_noise_estimation.sv
// Bench for noise_estimation (N=4, 8-bit samples); honours NOISE_EST_MIN_EN for expectations.
module tb_noise_estimation;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int NV = 19;
`ifdef NOISE_EST_MIN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 35;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_of_frame = 1'b0;
  logic          start_data = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [31:0]   blocks_per_frame = '0;
  logic [2*DW-1:0] estimated_noise;
  logic            estimated_noise_ready;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        sof;
    logic        glitch;
    logic        last;
    logic [31:0] bpf;
    logic [31:0] smp;
    logic [15:0] exp_avg;
    logic [15:0] exp_min;
  } vec_t;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vec[NV];

  noise_estimation #(
    .DATA_WIDTH   (DW),
    .TOTAL_SAMPLES(N)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start_of_frame       (start_of_frame),
    .start_data           (start_data),
    .data_in              (data_in),
    .blocks_per_frame     (blocks_per_frame),
    .estimated_noise      (estimated_noise),
    .estimated_noise_ready(estimated_noise_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input logic sof, input logic glitch, input logic last,
                              input logic [31:0] bpf, input logic [31:0] smp,
                              input int ea, input int em);
    vec_t v;
    v.sof = sof; v.glitch = glitch; v.last = last; v.bpf = bpf; v.smp = smp;
    v.exp_avg = 16'(ea); v.exp_min = 16'(em);
    return v;
  endfunction

  // samples 16b+4, +8, +12, +16: block variance 20
  function automatic logic [31:0] ramp(input int b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(16 * b + 4 * i + 4);
    return r;
  endfunction

  task automatic drive_block(input vec_t b, input bit push, input int expv);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      start_data       = (i == 0) || (b.glitch && i == 2);
      start_of_frame   = (i == 0) && b.sof;
      blocks_per_frame = b.bpf;
      data_in          = b.smp[8*i +: 8];
    end
    if (push) begin
      e.val = expv;
      e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start_data     = 1'b0;
    start_of_frame = 1'b0;
    data_in        = DW'($urandom);
    @(posedge clk); #1;
  endtask

  initial begin
    int ev;
    vec[0]  = mk(0, 0, 1, 0, ramp(0), 20, 20);
    vec[1]  = mk(1, 0, 0, 4, ramp(0), 0, 0);
    vec[2]  = mk(0, 0, 0, 4, ramp(1), 0, 0);
    vec[3]  = mk(0, 0, 0, 4, ramp(2), 0, 0);
    vec[4]  = mk(0, 0, 1, 4, ramp(3), 20, 20);
    vec[5]  = mk(1, 0, 1, 1, {4{8'd50}}, 0, 0);
    vec[6]  = mk(1, 0, 1, 1, {8'd255, 8'd0, 8'd255, 8'd0}, 16256, 16256);
    vec[7]  = mk(1, 1, 0, 2, ramp(0), 0, 0);
    vec[8]  = mk(0, 0, 1, 2, {4{8'd9}}, 10, 0);
    vec[9]  = mk(1, 0, 1, 0, {8'd4, 8'd3, 8'd2, 8'd1}, 1, 1);
    vec[10] = mk(1, 0, 0, 3, {8'd255, 8'd0, 8'd0, 8'd0}, 0, 0);
    vec[11] = mk(0, 0, 0, 3, {8'd40, 8'd30, 8'd20, 8'd10}, 0, 0);
    vec[12] = mk(0, 0, 1, 3, {4{8'd255}}, 4105, 0);
    vec[13] = mk(1, 0, 0, 4, ramp(0), 0, 0);
    vec[14] = mk(0, 0, 0, 4, ramp(1), 0, 0);
    vec[15] = mk(1, 0, 0, 4, ramp(1), 0, 0);
    vec[16] = mk(0, 0, 0, 4, ramp(2), 0, 0);
    vec[17] = mk(0, 0, 0, 4, ramp(3), 0, 0);
    vec[18] = mk(0, 0, 1, 4, ramp(4), 20, 20);

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (estimated_noise_ready === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_ready: ready at cycle %0d with noise %0d, expected no ready",
                     cyc, estimated_noise);
          end else begin
            e = sb.pop_front();
            check("noise", estimated_noise, e.val);
            check("ready_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_noise", estimated_noise, 0);
    check("reset_ready", estimated_noise_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("post_reset_ready", estimated_noise_ready, 0);

    for (int i = 0; i < NV; i++) begin
`ifdef NOISE_EST_MIN_EN
      ev = vec[i].exp_min;
`else
      ev = vec[i].exp_avg;
`endif
      drive_block(vec[i], vec[i].last, ev);
      if (vec[i].last) begin
        repeat (40) @(posedge clk);
        #1;
      end
    end

    // new frame issued while the previous one is still dividing
`ifdef NOISE_EST_MIN_EN
    drive_block(mk(1, 0, 1, 1, ramp(0), 0, 0), 1'b1, 20);
`else
    drive_block(mk(1, 0, 1, 1, ramp(0), 0, 0), 1'b0, 0);
`endif
    repeat (8) @(posedge clk);
    #1;
    drive_block(mk(1, 0, 1, 1, {4{8'd50}}, 0, 0), 1'b1, 0);
    repeat (40) @(posedge clk);
    #1;

    // reset after two of four blocks, then a flat frame
    drive_block(mk(1, 0, 0, 4, ramp(0), 0, 0), 1'b0, 0);
    drive_block(mk(0, 0, 0, 4, ramp(1), 0, 0), 1'b0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_noise", estimated_noise, 0);
    check("midframe_reset_ready", estimated_noise_ready, 0);
    #1;
    drive_block(mk(1, 0, 0, 4, {4{8'd7}}, 0, 0), 1'b0, 0);
    drive_block(mk(0, 0, 0, 4, {4{8'd7}}, 0, 0), 1'b0, 0);
    drive_block(mk(0, 0, 0, 4, {4{8'd7}}, 0, 0), 1'b0, 0);
    drive_block(mk(0, 0, 1, 4, {4{8'd7}}, 0, 0), 1'b1, 0);

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    check("pending_results", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
